// File: rtl/ahmes_control_unit.sv
// ahmes_control_unit: Moore micro-sequencer for the Ahmes 8-bit CPU. It fetches and decodes
//   each instruction and drives the PC/REM/RDM/RI/AC/flag strobes and the ALU op select.
// Latency: strobes are decoded from the state register (plus ri_in/flags from T3 on) and take
//   effect at the next rising edge. NOP/NOT/shift/untaken jump 4, taken jump 6, STA 7, LDA/ALU 8.
// Backpressure: none. Memory answers in one cycle. HALT is left only through reset.
// Ports: clk, reset (async, active-low), ri_in[7:0], flag_n/z/v/c/b in;
//   load_ac, load_pc, inc_pc, load_rem, load_rdm, load_ri, mem_write, sel_rem,
//   load_nz, load_v, load_c, load_b, alu_op[3:0], halted, illegal, state[3:0] out.
// Option: define AHMES_CU_ILLEGAL_TRAP_EN so that undefined opcodes halt the unit and set
//   the sticky 'illegal' output. Without it they run as a 4-cycle NOP and 'illegal' is 0.
module ahmes_control_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ri_in,
  input  logic       flag_n,
  input  logic       flag_z,
  input  logic       flag_v,
  input  logic       flag_c,
  input  logic       flag_b,
  output logic       load_ac,
  output logic       load_pc,
  output logic       inc_pc,
  output logic       load_rem,
  output logic       load_rdm,
  output logic       load_ri,
  output logic       mem_write,
  output logic       sel_rem,
  output logic       load_nz,
  output logic       load_v,
  output logic       load_c,
  output logic       load_b,
  output logic [3:0] alu_op,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state
);

  // The state sequence assumes the RDM holds read data one cycle after load_rem.
  if (MEM_RD_LAT != 1) begin : g_bad_mem_rd_lat
    $error("ahmes_control_unit: only MEM_RD_LAT = 1 is supported");
  end

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    T7   = 4'd7,
    HALT = 4'd8
  } state_e;

  localparam logic [3:0] ALU_PASS_B = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_OR     = 4'd2;
  localparam logic [3:0] ALU_AND    = 4'd3;
  localparam logic [3:0] ALU_NOT    = 4'd4;
  localparam logic [3:0] ALU_SUB    = 4'd5;
  localparam logic [3:0] ALU_SHR    = 4'd6;

  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SUB = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JNV = 4'h9;  // JN / JP / JV / JNV
  localparam logic [3:0] OP_JZ  = 4'hA;  // JZ / JNZ
  localparam logic [3:0] OP_JCB = 4'hB;  // JC / JNC / JB / JNB
  localparam logic [3:0] OP_SHF = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_e     state_q, state_d;
  logic [3:0] op;
  logic [1:0] jsub;
  logic       is_mem, is_jump, jump_taken, op_undef;

  assign op   = ri_in[7:4];
  assign jsub = ri_in[3:2];

  // Instruction class decode. jump_taken is only consumed in T3, so the flags are
  // sampled exactly once per instruction.
  always_comb begin
    is_mem     = 1'b0;
    is_jump    = 1'b0;
    jump_taken = 1'b0;
    op_undef   = 1'b0;
    case (op)
      OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_SUB: is_mem = 1'b1;
      OP_JMP: begin
        is_jump    = 1'b1;
        jump_taken = 1'b1;
      end
      OP_JNV: begin
        is_jump = 1'b1;
        case (jsub)
          2'd0:    jump_taken = flag_n;
          2'd1:    jump_taken = !flag_n;
          2'd2:    jump_taken = flag_v;
          default: jump_taken = !flag_v;
        endcase
      end
      OP_JZ: begin
        if (jsub[1]) begin
          op_undef = 1'b1;
        end else begin
          is_jump    = 1'b1;
          jump_taken = jsub[0] ? !flag_z : flag_z;
        end
      end
      OP_JCB: begin
        is_jump = 1'b1;
        case (jsub)
          2'd0:    jump_taken = flag_c;
          2'd1:    jump_taken = !flag_c;
          2'd2:    jump_taken = flag_b;
          default: jump_taken = !flag_b;
        endcase
      end
      4'hC, 4'hD: op_undef = 1'b1;
      default: ;
    endcase
  end

  // Control vector and next state. Everything stays at zero while reset is held,
  // because the async reset parks the register in T0, which would otherwise assert load_rem.
  always_comb begin
    state_d   = state_q;
    load_ac   = 1'b0;
    load_pc   = 1'b0;
    inc_pc    = 1'b0;
    load_rem  = 1'b0;
    load_rdm  = 1'b0;
    load_ri   = 1'b0;
    mem_write = 1'b0;
    sel_rem   = 1'b0;
    load_nz   = 1'b0;
    load_v    = 1'b0;
    load_c    = 1'b0;
    load_b    = 1'b0;
    alu_op    = ALU_PASS_B;
    if (reset) begin
      case (state_q)
        T0: begin
          load_rem = 1'b1;  // REM <- PC
          state_d  = T1;
        end
        T1: begin
          load_rdm = 1'b1;
          inc_pc   = 1'b1;
          state_d  = T2;
        end
        T2: begin
          load_ri = 1'b1;
          state_d = T3;
        end
        T3: begin
          state_d = T0;
          if (op == OP_HLT) begin
            state_d = HALT;
          end else if (op == OP_NOT) begin
            load_ac = 1'b1;
            alu_op  = ALU_NOT;
            load_nz = 1'b1;
          end else if (op == OP_SHF) begin
            // sub-op 0..3 selects SHR, SHL, ROR, ROL, which are consecutive ALU codes.
            load_ac = 1'b1;
            alu_op  = ALU_SHR + {2'b00, ri_in[1:0]};
            load_nz = 1'b1;
            load_c  = 1'b1;
          end else if (is_mem || (is_jump && jump_taken)) begin
            load_rem = 1'b1;  // fetch the operand byte
            state_d  = T4;
          end else if (is_jump) begin
            inc_pc = 1'b1;    // untaken: step over the operand byte
          end
`ifdef AHMES_CU_ILLEGAL_TRAP_EN
          else if (op_undef) begin
            state_d = HALT;
          end
`endif
        end
        T4: begin
          load_rdm = 1'b1;
          inc_pc   = 1'b1;
          state_d  = T5;
        end
        T5: begin
          // Only taken jumps reach T4, so a jump opcode here always loads the PC.
          if (is_jump) begin
            load_pc = 1'b1;
            state_d = T0;
          end else begin
            sel_rem  = 1'b1;  // REM <- RDM (operand address)
            load_rem = 1'b1;
            state_d  = T6;
          end
        end
        T6: begin
          if (op == OP_STA) begin
            mem_write = 1'b1;
            state_d   = T0;
          end else begin
            load_rdm = 1'b1;
            state_d  = T7;
          end
        end
        T7: begin
          load_ac = 1'b1;
          load_nz = 1'b1;
          state_d = T0;
          case (op)
            OP_ADD: begin
              alu_op = ALU_ADD;
              load_v = 1'b1;
              load_c = 1'b1;
            end
            OP_OR:  alu_op = ALU_OR;
            OP_AND: alu_op = ALU_AND;
            OP_SUB: begin
              alu_op = ALU_SUB;
              load_v = 1'b1;
              load_b = 1'b1;
            end
            default: alu_op = ALU_PASS_B;  // LDA
          endcase
        end
        HALT:    state_d = HALT;
        default: state_d = T0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef AHMES_CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else if (state_q == T3 && op_undef) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign halted = (state_q == HALT);
  assign state  = state_q;

endmodule
